// File: rtl/psum_merge_unit.sv
// Merges PE results with externally supplied partial sums ahead of the output buffer.
// Four merge modes, a parallel-write psum FIFO and optional saturating arithmetic.
module psum_merge_unit #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned PSUM_WIDTH = 20,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned PSUM_DEPTH = 8,
  parameter int unsigned PAR_WRITE  = 2,
  parameter int unsigned SATURATE   = 1,
  localparam int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            start,
  input  logic                            stop,
  input  logic [1:0]                      mode,
  input  logic                            pe_valid,
  output logic                            pe_ready,
  input  logic [DATA_WIDTH-1:0]           pe_data,
  input  logic [CH_W-1:0]                 pe_ch,
  input  logic                            pe_last,
  input  logic                            psum_wen,
  input  logic [PAR_WRITE*PSUM_WIDTH-1:0] psum_din,
  output logic                            psum_full,
  output logic                            psum_empty,
  output logic                            overflow,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [PSUM_WIDTH-1:0]           out_data,
  output logic [CH_W-1:0]                 out_ch,
  output logic                            busy,
  output logic                            done
);

  localparam int unsigned PTR_W = (PSUM_DEPTH > 1) ? $clog2(PSUM_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(PSUM_DEPTH + 1);

  localparam logic signed [PSUM_WIDTH-1:0] PsumMax = {1'b0, {(PSUM_WIDTH-1){1'b1}}};
  localparam logic signed [PSUM_WIDTH-1:0] PsumMin = {1'b1, {(PSUM_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;
  typedef enum logic [1:0] {
    ModePass  = 2'b00,
    ModeAccum = 2'b01,
    ModeAdd   = 2'b10,
    ModeLocal = 2'b11
  } mode_e;

  state_e                        state_q, state_d;
  mode_e                         mode_q, mode_d;
  logic signed [PSUM_WIDTH-1:0]  mem_q [PSUM_DEPTH];
  logic signed [PSUM_WIDTH-1:0]  mem_d [PSUM_DEPTH];
  logic [PTR_W-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          overflow_q, overflow_d;
  logic signed [PSUM_WIDTH-1:0]  acc_q [NUM_CH];
  logic signed [PSUM_WIDTH-1:0]  acc_d [NUM_CH];
  logic [CH_W-1:0]               rr_q, rr_d;
  logic                          out_valid_q, out_valid_d;
  logic signed [PSUM_WIDTH-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]               out_ch_q, out_ch_d;

  logic signed [PSUM_WIDTH-1:0]  pe_ext;
  logic signed [PSUM_WIDTH-1:0]  head;
  logic signed [PSUM_WIDTH-1:0]  local_sum;
  logic [CNT_W-1:0]              free_slots;
  logic                          fifo_full;
  logic                          fifo_empty;
  logic                          wr_en;
  logic                          slot_free;
  logic                          can_issue;
  logic                          pe_fire;
  logic                          pop;

  // Sum is formed one bit wider so the carry-out reveals signed overflow.
  function automatic logic signed [PSUM_WIDTH-1:0] add_fn(
    input logic signed [PSUM_WIDTH-1:0] a,
    input logic signed [PSUM_WIDTH-1:0] b
  );
    logic signed [PSUM_WIDTH:0] s;
    s = {a[PSUM_WIDTH-1], a} + {b[PSUM_WIDTH-1], b};
    if ((SATURATE != 0) && (s[PSUM_WIDTH] != s[PSUM_WIDTH-1])) begin
      return s[PSUM_WIDTH] ? PsumMin : PsumMax;
    end
    return s[PSUM_WIDTH-1:0];
  endfunction

  assign pe_ext     = PSUM_WIDTH'($signed(pe_data));
  assign head       = mem_q[rd_ptr_q];
  assign local_sum  = add_fn(acc_q[pe_ch], pe_ext);
  assign free_slots = CNT_W'(PSUM_DEPTH) - cnt_q;
  assign fifo_full  = free_slots < CNT_W'(PAR_WRITE);
  assign fifo_empty = (cnt_q == '0);
  assign wr_en      = psum_wen && !fifo_full;

  assign slot_free  = !out_valid_q || out_ready;
  assign can_issue  = (state_q == StRun) && slot_free;

  always_comb begin
    pe_ready = 1'b0;
    unique case (mode_q)
      ModePass:  pe_ready = can_issue;
      ModeAccum: pe_ready = can_issue && !fifo_empty;
      ModeAdd:   pe_ready = 1'b0;
      ModeLocal: pe_ready = can_issue;
      default:   pe_ready = 1'b0;
    endcase
  end

  assign pe_fire = pe_valid && pe_ready;
  assign pop     = ((mode_q == ModeAccum) && pe_fire) ||
                   ((mode_q == ModeAdd) && can_issue && !fifo_empty);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    overflow_d  = overflow_q;
    acc_d       = acc_q;
    rr_d        = rr_q;
    out_valid_d = slot_free ? 1'b0 : out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StRun;
          mode_d     = mode_e'(mode);
          acc_d      = '{default: '0};
          overflow_d = 1'b0;
          rr_d       = '0;
        end
      end
      StRun: begin
        if (stop) state_d = StDrain;
      end
      StDrain: begin
        if (slot_free) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    unique case (mode_q)
      ModePass: begin
        if (pe_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = pe_ext;
          out_ch_d    = pe_ch;
        end
      end
      ModeAccum: begin
        if (pe_fire) begin
          out_valid_d = 1'b1;
          out_data_d  = add_fn(pe_ext, head);
          out_ch_d    = pe_ch;
        end
      end
      ModeAdd: begin
        if (pop) begin
          out_valid_d = 1'b1;
          out_data_d  = head;
          out_ch_d    = rr_q;
          rr_d        = (rr_q == CH_W'(NUM_CH - 1)) ? '0 : rr_q + CH_W'(1);
        end
      end
      ModeLocal: begin
        if (pe_fire) begin
          if (pe_last) begin
            out_valid_d  = 1'b1;
            out_data_d   = local_sum;
            out_ch_d     = pe_ch;
            acc_d[pe_ch] = '0;
          end else begin
            acc_d[pe_ch] = local_sum;
          end
        end
      end
      default: ;
    endcase

    // Writes are accepted in every state; a write that does not fit is dropped whole.
    if (psum_wen) begin
      if (wr_en) begin
        for (int i = 0; i < int'(PAR_WRITE); i++) begin
          mem_d[wr_ptr_q + PTR_W'(i)] = psum_din[i*PSUM_WIDTH +: PSUM_WIDTH];
        end
        wr_ptr_d = wr_ptr_q + PTR_W'(PAR_WRITE);
      end else begin
        overflow_d = 1'b1;
      end
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + (wr_en ? CNT_W'(PAR_WRITE) : '0) - (pop ? CNT_W'(1) : '0);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StIdle;
      mode_q      <= ModePass;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      overflow_q  <= 1'b0;
      acc_q       <= '{default: '0};
      rr_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      overflow_q  <= overflow_d;
      acc_q       <= acc_d;
      rr_q        <= rr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
    end
  end

  assign psum_full  = fifo_full;
  assign psum_empty = fifo_empty;
  assign overflow   = overflow_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDrain) && slot_free;

endmodule

// File: tb/tb_psum_merge_unit.sv
// Directed bench for psum_merge_unit with a scoreboard of expected output beats.
// A second instance with wrapping arithmetic is compared in the saturation step.
module tb_psum_merge_unit;

  localparam int unsigned DW = 16;
  localparam int unsigned PW = 20;
  localparam int unsigned CW = 2;

  logic          clk;
  logic          rstn;
  logic          start, stop;
  logic [1:0]    mode;
  logic          pe_valid, pe_last;
  logic [DW-1:0] pe_data;
  logic [CW-1:0] pe_ch;
  logic          psum_wen;
  logic [2*PW-1:0] psum_din;
  logic          out_ready;

  logic          pe_ready, psum_full, psum_empty, overflow, out_valid, busy, done;
  logic [PW-1:0] out_data;
  logic [CW-1:0] out_ch;

  logic          w_pe_ready, w_psum_full, w_psum_empty, w_overflow, w_out_valid, w_busy, w_done;
  logic [PW-1:0] w_out_data;
  logic [CW-1:0] w_out_ch;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CW+PW-1:0] sb[$];

  psum_merge_unit #(.SATURATE(1)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .mode(mode),
    .pe_valid(pe_valid), .pe_ready(pe_ready), .pe_data(pe_data), .pe_ch(pe_ch),
    .pe_last(pe_last), .psum_wen(psum_wen), .psum_din(psum_din), .psum_full(psum_full),
    .psum_empty(psum_empty), .overflow(overflow), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch), .busy(busy), .done(done)
  );

  psum_merge_unit #(.SATURATE(0)) u_wrap (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .mode(mode),
    .pe_valid(pe_valid), .pe_ready(w_pe_ready), .pe_data(pe_data), .pe_ch(pe_ch),
    .pe_last(pe_last), .psum_wen(psum_wen), .psum_din(psum_din), .psum_full(w_psum_full),
    .psum_empty(w_psum_empty), .overflow(w_overflow), .out_valid(w_out_valid),
    .out_ready(out_ready), .out_data(w_out_data), .out_ch(w_out_ch), .busy(w_busy),
    .done(w_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [CW-1:0] ch, input logic [PW-1:0] d);
    sb.push_back({ch, d});
  endtask

  task automatic finish_run();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    for (int i = 0; i < 20 && !done; i++) tick();
    chk("done_pulse", {31'd0, done}, 32'd1);
    tick();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_done", {31'd0, done}, 32'd0);
  endtask

  // Output beats are compared when a transfer is about to occur on the next edge.
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      logic [CW+PW-1:0] e;
      n_checks++;
      assert (sb.size() != 0) else begin
        n_fail++;
        $error("FAIL sb_unexpected observed=%0h expected=none", {out_ch, out_data});
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        assert ({out_ch, out_data} === e) else begin
          n_fail++;
          $error("FAIL sb_beat observed=%0h expected=%0h", {out_ch, out_data}, e);
        end
      end
    end
  end

  initial begin
    int l_data [6] = '{10, 1, 20, 2, 30, 7};
    int l_ch   [6] = '{0, 1, 0, 1, 0, 0};
    int l_last [6] = '{0, 0, 0, 1, 1, 1};
    int model_acc [4];

    rstn = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'b00;
    pe_valid = 1'b0; pe_last = 1'b0; pe_data = '0; pe_ch = '0;
    psum_wen = 1'b0; psum_din = '0; out_ready = 1'b0;
    tick(); tick();
    chk("rst_pe_ready", {31'd0, pe_ready}, 32'd0);
    chk("rst_full", {31'd0, psum_full}, 32'd0);
    chk("rst_empty", {31'd0, psum_empty}, 32'd1);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_ch", 32'(out_ch), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rstn = 1'b1;
    tick();

    // PASS: -5 on channel 2 is sign-extended and appears one cycle later.
    mode = 2'b00; start = 1'b1;
    tick();
    start = 1'b0;
    chk("pass_busy", {31'd0, busy}, 32'd1);
    out_ready = 1'b1; pe_valid = 1'b1; pe_data = 16'hFFFB; pe_ch = 2'd2;
    #1;
    chk("pass_pe_ready", {31'd0, pe_ready}, 32'd1);
    push(2'd2, 20'hFFFFB);
    tick();
    pe_valid = 1'b0;
    chk("pass_out_valid", {31'd0, out_valid}, 32'd1);
    chk("pass_out_data", 32'(out_data), 32'h000FFFFB);
    finish_run();

    // ACCUM with one stall cycle.
    psum_wen = 1'b1; psum_din = {20'd200, 20'd100};
    tick();
    psum_wen = 1'b0;
    chk("accum_not_empty", {31'd0, psum_empty}, 32'd0);
    mode = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1; pe_valid = 1'b1; pe_data = 16'd3; pe_ch = 2'd1;
    push(2'd1, 20'd103);
    tick();
    out_ready = 1'b0; pe_data = 16'd4;
    #1;
    chk("accum_stall_ready", {31'd0, pe_ready}, 32'd0);
    tick();
    chk("accum_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("accum_hold_data", 32'(out_data), 32'd103);
    out_ready = 1'b1;
    push(2'd1, 20'd204);
    tick();
    pe_valid = 1'b0;
    chk("accum_out_204", 32'(out_data), 32'd204);
    chk("accum_empty_after", {31'd0, psum_empty}, 32'd1);
    tick();
    finish_run();

    // FIFO fill to 8, dropped 5th write, then ADD_ONLY drain with pop+write boundaries.
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      psum_wen = 1'b1;
      psum_din = {20'(2 * k + 2), 20'(2 * k + 1)};
      tick();
      psum_wen = 1'b0;
      chk("fill_full", {31'd0, psum_full}, (k == 3) ? 32'd1 : 32'd0);
    end
    psum_wen = 1'b1; psum_din = {20'd99, 20'd98};
    tick();
    psum_wen = 1'b0;
    chk("fill_overflow", {31'd0, overflow}, 32'd1);
    chk("fill_still_full", {31'd0, psum_full}, 32'd1);
    mode = 2'b10; start = 1'b1;
    tick();
    start = 1'b0;
    chk("add_ovf_cleared", {31'd0, overflow}, 32'd0);
    chk("add_pe_ready", {31'd0, pe_ready}, 32'd0);
    push(2'd0, 20'd1);
    tick();
    chk("occ7_full", {31'd0, psum_full}, 32'd1);
    psum_wen = 1'b1; psum_din = {20'd11, 20'd10}; out_ready = 1'b1;
    push(2'd1, 20'd2);
    tick();
    chk("occ7_write_dropped", {31'd0, overflow}, 32'd1);
    chk("occ6_not_full", {31'd0, psum_full}, 32'd0);
    psum_din = {20'd13, 20'd12};
    push(2'd2, 20'd3);
    tick();
    psum_wen = 1'b0;
    chk("occ6_pop_write_full", {31'd0, psum_full}, 32'd1);
    push(2'd3, 20'd4); push(2'd0, 20'd5); push(2'd1, 20'd6); push(2'd2, 20'd7);
    push(2'd3, 20'd8); push(2'd0, 20'd12); push(2'd1, 20'd13);
    for (int i = 0; i < 30 && !(psum_empty && !out_valid); i++) tick();
    chk("add_sb_drained", 32'(sb.size()), 32'd0);
    finish_run();

    // LOCAL: interleaved channels, only pe_last rows emit.
    model_acc = '{0, 0, 0, 0};
    mode = 2'b11; start = 1'b1;
    tick();
    start = 1'b0;
    out_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      pe_valid = 1'b1; pe_data = 16'(l_data[r]); pe_ch = 2'(l_ch[r]); pe_last = l_last[r][0];
      #1;
      chk("local_pe_ready", {31'd0, pe_ready}, 32'd1);
      model_acc[l_ch[r]] += l_data[r];
      if (l_last[r] != 0) begin
        push(2'(l_ch[r]), 20'(model_acc[l_ch[r]]));
        model_acc[l_ch[r]] = 0;
      end
      tick();
    end
    pe_valid = 1'b0; pe_last = 1'b0;
    tick(); tick();
    chk("local_sb_drained", 32'(sb.size()), 32'd0);
    finish_run();

    // Saturation vs wrap at both ends of the 20-bit range.
    psum_wen = 1'b1; psum_din = {20'h80000, 20'h7FFFF};
    tick();
    psum_wen = 1'b0;
    mode = 2'b01; start = 1'b1;
    tick();
    start = 1'b0;
    pe_valid = 1'b1; pe_data = 16'd1; pe_ch = 2'd0;
    push(2'd0, 20'h7FFFF);
    tick();
    chk("wrap_pos", 32'(w_out_data), 32'h00080000);
    pe_data = 16'hFFFF;
    push(2'd0, 20'h80000);
    tick();
    pe_valid = 1'b0;
    chk("wrap_neg", 32'(w_out_data), 32'h0007FFFF);
    tick();
    finish_run();

    // Stop with one output stalled.
    mode = 2'b00; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    pe_valid = 1'b1; pe_data = 16'd9; pe_ch = 2'd3;
    push(2'd3, 20'd9);
    tick();
    pe_valid = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("drain_busy", {31'd0, busy}, 32'd1);
    chk("drain_no_done", {31'd0, done}, 32'd0);
    tick();
    chk("drain_still_valid", {31'd0, out_valid}, 32'd1);
    chk("drain_still_no_done", {31'd0, done}, 32'd0);
    out_ready = 1'b1;
    #1;
    chk("drain_done", {31'd0, done}, 32'd1);
    tick();
    chk("drain_idle", {31'd0, busy}, 32'd0);
    chk("drain_done_low", {31'd0, done}, 32'd0);

    // Asynchronous reset mid-RUN.
    psum_wen = 1'b1; psum_din = {20'd5, 20'd6};
    tick();
    psum_wen = 1'b0;
    mode = 2'b00; start = 1'b1; out_ready = 1'b0;
    tick();
    start = 1'b0;
    pe_valid = 1'b1; pe_data = 16'd77; pe_ch = 2'd1;
    tick();
    pe_valid = 1'b0;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_data", 32'(out_data), 32'd0);
    chk("arst_out_ch", 32'(out_ch), 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_empty", {31'd0, psum_empty}, 32'd1);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    tick();
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
